// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg -- shared definitions for the Lab9 processor control sequencer.
//   Opcode values, timestep (state) encoding, ALU operation codes and the
//   IR field layout (IIIXXXYYY at the default register-select width).
//   Optional feature macro: PROC_CTRL_LOGIC_EN (adds and/or opcodes 100/101).
package proc_ctrl_pkg;

  localparam int REG_SEL_W_DEF = 3;
  localparam int OPC_W         = 3;

  localparam logic [OPC_W-1:0] OPC_MV  = 3'b000;
  localparam logic [OPC_W-1:0] OPC_MVI = 3'b001;
  localparam logic [OPC_W-1:0] OPC_ADD = 3'b010;
  localparam logic [OPC_W-1:0] OPC_SUB = 3'b011;
  localparam logic [OPC_W-1:0] OPC_AND = 3'b100;
  localparam logic [OPC_W-1:0] OPC_OR  = 3'b101;

  typedef enum logic [1:0] {
    ST_T0 = 2'd0,
    ST_T1 = 2'd1,
    ST_T2 = 2'd2,
    ST_T3 = 2'd3
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // IR layout: opcode on top, then X (destination / first operand), then Y.
  localparam int RY_LSB = 0;

  function automatic int ir_width(input int rsw);
    return OPC_W + 2 * rsw;
  endfunction

  function automatic int opc_lsb(input int rsw);
    return 2 * rsw;
  endfunction

  function automatic int rx_lsb(input int rsw);
    return rsw;
  endfunction

  // Opcodes that run the three-step A/G sequence through the ALU.
  function automatic logic is_alu_opc(input logic [OPC_W-1:0] opc);
`ifdef PROC_CTRL_LOGIC_EN
    return (opc == OPC_ADD) || (opc == OPC_SUB) ||
           (opc == OPC_AND) || (opc == OPC_OR);
`else
    return (opc == OPC_ADD) || (opc == OPC_SUB);
`endif
  endfunction

  // Anything not recognised falls back to add so ALU_OP never shows an
  // unsupported code.
  function automatic logic [1:0] alu_code(input logic [OPC_W-1:0] opc);
    logic [1:0] code;
    code = ALU_ADD;
    case (opc)
      OPC_SUB: code = ALU_SUB;
`ifdef PROC_CTRL_LOGIC_EN
      OPC_AND: code = ALU_AND;
      OPC_OR:  code = ALU_OR;
`endif
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/onehot_dec3to8.sv
// onehot_dec3to8 -- register-select to one-hot decoder with enable.
//   en      in   1      Decoder enable; output is all zero when low.
//   sel     in   SEL_W  Register index.
//   onehot  out  N      One-hot select, N = 2**SEL_W.
module onehot_dec3to8 #(
  parameter  int SEL_W = 3,
  localparam int N     = 2 ** SEL_W
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm -- control sequencer for the Lab9 simple processor.
//   Latches a 9-bit instruction IIIXXXYYY and steps it through T0..T3,
//   producing register enables, bus-driver selects, ALU controls and DONE.
//   Optional feature macro: PROC_CTRL_LOGIC_EN (opcode 100 = and, 101 = or).
// Ports:
//   CLK, RST            clock / asynchronous active-high reset
//   RUN                 start request, sampled in T0 only
//   DIN      [IR_W]     instruction in T0, immediate in T1 of mvi
//   IR_Q     [IR_W]     latched instruction
//   R_IN     [NREG]     one-hot register write enable (X)
//   R_OUT    [NREG]     one-hot register bus drive (X or Y)
//   DIN_OUT, G_OUT      DIN / G drive the bus
//   A_IN, G_IN          load A from bus / load G with ALU result
//   ALU_OP   [2]        00 add, 01 sub, 10 and, 11 or
//   DONE, ILLEGAL       completion pulse / unsupported-opcode pulse
//   STATE_DBG [2]       current timestep (0..3) for observation
// Handshake: RUN is a level start request. When the sequencer is in T0 and
//   RUN=1 at a rising edge, DIN is captured into IR and the instruction runs;
//   RUN is ignored until the sequencer returns to T0. DONE pulses for one
//   cycle in the last step, so a held RUN starts the next instruction in the
//   T0 cycle right after DONE.
module proc_ctrl_fsm
  import proc_ctrl_pkg::*;
#(
  parameter  int REG_SEL_W = REG_SEL_W_DEF,
  localparam int NREG      = 2 ** REG_SEL_W,
  localparam int IR_W      = 3 + 2 * REG_SEL_W
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RUN,
  input  logic [IR_W-1:0] DIN,
  output logic [IR_W-1:0] IR_Q,
  output logic [NREG-1:0] R_IN,
  output logic [NREG-1:0] R_OUT,
  output logic            DIN_OUT,
  output logic            G_OUT,
  output logic            A_IN,
  output logic            G_IN,
  output logic [1:0]      ALU_OP,
  output logic            DONE,
  output logic            ILLEGAL,
  output logic [1:0]      STATE_DBG
);

  localparam int OPC_LSB = opc_lsb(REG_SEL_W);
  localparam int RX_LSB  = rx_lsb(REG_SEL_W);

  state_t                 state_q;
  state_t                 state_d;
  logic [IR_W-1:0]        ir_q;
  logic [OPC_W-1:0]       opc;
  logic [REG_SEL_W-1:0]   rx;
  logic [REG_SEL_W-1:0]   ry;
  logic [REG_SEL_W-1:0]   r_out_sel;
  logic                   r_in_en;
  logic                   r_out_en;

  assign opc = ir_q[OPC_LSB +: OPC_W];
  assign rx  = ir_q[RX_LSB +: REG_SEL_W];
  assign ry  = ir_q[RY_LSB +: REG_SEL_W];

  assign IR_Q      = ir_q;
  assign STATE_DBG = state_q;

  // State and instruction register; reset clears both mid-instruction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_T0) && RUN) begin
        ir_q <= DIN;
      end
    end
  end

  // Next state and control outputs. Outputs depend only on (state, IR);
  // RUN only steers the T0 -> T1 transition.
  always_comb begin
    state_d   = state_q;
    r_in_en   = 1'b0;
    r_out_en  = 1'b0;
    r_out_sel = rx;
    DIN_OUT   = 1'b0;
    G_OUT     = 1'b0;
    A_IN      = 1'b0;
    G_IN      = 1'b0;
    ALU_OP    = ALU_ADD;
    DONE      = 1'b0;
    ILLEGAL   = 1'b0;

    case (state_q)
      ST_T0: begin
        if (RUN) begin
          state_d = ST_T1;
        end
      end

      ST_T1: begin
        if (opc == OPC_MV) begin
          r_out_en  = 1'b1;
          r_out_sel = ry;
          r_in_en   = 1'b1;
          DONE      = 1'b1;
          state_d   = ST_T0;
        end else if (opc == OPC_MVI) begin
          DIN_OUT = 1'b1;
          r_in_en = 1'b1;
          DONE    = 1'b1;
          state_d = ST_T0;
        end else if (is_alu_opc(opc)) begin
          // First operand X goes to A.
          r_out_en  = 1'b1;
          r_out_sel = rx;
          A_IN      = 1'b1;
          state_d   = ST_T2;
        end else begin
          // Unsupported opcode: finish at once with nothing on the bus.
          DONE    = 1'b1;
          ILLEGAL = 1'b1;
          state_d = ST_T0;
        end
      end

      ST_T2: begin
        // Second operand Y on the bus, ALU result captured in G.
        r_out_en  = 1'b1;
        r_out_sel = ry;
        G_IN      = 1'b1;
        ALU_OP    = alu_code(opc);
        state_d   = ST_T3;
      end

      ST_T3: begin
        // G writes the result back to X.
        G_OUT   = 1'b1;
        r_in_en = 1'b1;
        DONE    = 1'b1;
        state_d = ST_T0;
      end

      default: begin
        state_d = ST_T0;
      end
    endcase
  end

  onehot_dec3to8 #(.SEL_W(REG_SEL_W)) u_dec_rin (
    .en     (r_in_en),
    .sel    (rx),
    .onehot (R_IN)
  );

  onehot_dec3to8 #(.SEL_W(REG_SEL_W)) u_dec_rout (
    .en     (r_out_en),
    .sel    (r_out_sel),
    .onehot (R_OUT)
  );

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb_proc_ctrl_fsm -- bench for proc_ctrl_fsm.
//   A per-instruction step list is built from the instruction semantics and
//   consumed one entry per cycle; every negative edge the DUT outputs are
//   compared against the head of that list (or the idle T0 value).
//   Build with +define+PROC_CTRL_LOGIC_EN to exercise and/or.
module tb_proc_ctrl_fsm;

  localparam int W = 35;

  logic       clk;
  logic       rst;
  logic       run;
  logic [8:0] din;
  logic [8:0] ir_q;
  logic [7:0] r_in;
  logic [7:0] r_out;
  logic       din_out;
  logic       g_out;
  logic       a_in;
  logic       g_in;
  logic [1:0] alu_op;
  logic       done;
  logic       illegal;
  logic [1:0] state_dbg;

  int vectors;
  int miscompares;

  logic [W-1:0] exp_q[$];
  logic [8:0]   m_ir;
  bit           logic_en;
  int           done_cycles[$];

  proc_ctrl_fsm dut (
    .CLK       (clk),
    .RST       (rst),
    .RUN       (run),
    .DIN       (din),
    .IR_Q      (ir_q),
    .R_IN      (r_in),
    .R_OUT     (r_out),
    .DIN_OUT   (din_out),
    .G_OUT     (g_out),
    .A_IN      (a_in),
    .G_IN      (g_in),
    .ALU_OP    (alu_op),
    .DONE      (done),
    .ILLEGAL   (illegal),
    .STATE_DBG (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic [8:0] ir, input logic [7:0] rin,
                                      input logic [7:0] rout, input logic dout,
                                      input logic gout, input logic ain, input logic gin,
                                      input logic [1:0] alu, input logic dn,
                                      input logic il, input logic [1:0] st);
    return {ir, rin, rout, dout, gout, ain, gin, alu, dn, il, st};
  endfunction

  // Expand an instruction into the outputs expected on each step T1..Tn.
  task automatic model_load(input logic [8:0] ir);
    logic [2:0] opc;
    logic [7:0] ox;
    logic [7:0] oy;
    int         opn;
    opc  = ir[8:6];
    ox   = 8'd1 << ir[5:3];
    oy   = 8'd1 << ir[2:0];
    opn  = int'(opc);
    m_ir = ir;
    if (opn == 0) begin
      exp_q.push_back(pk(ir, ox, oy, 0, 0, 0, 0, 2'd0, 1, 0, 2'd1));
    end else if (opn == 1) begin
      exp_q.push_back(pk(ir, ox, 8'h00, 1, 0, 0, 0, 2'd0, 1, 0, 2'd1));
    end else if (opn == 2 || opn == 3 || (logic_en && (opn == 4 || opn == 5))) begin
      exp_q.push_back(pk(ir, 8'h00, ox, 0, 0, 1, 0, 2'd0, 0, 0, 2'd1));
      exp_q.push_back(pk(ir, 8'h00, oy, 0, 0, 0, 1, 2'(opn - 2), 0, 0, 2'd2));
      exp_q.push_back(pk(ir, ox, 8'h00, 0, 1, 0, 0, 2'd0, 1, 0, 2'd3));
    end else begin
      exp_q.push_back(pk(ir, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 1, 1, 2'd1));
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    logic [W-1:0] exp_now;
    logic [W-1:0] act_now;
    int           drivers;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_ir = '0;
      end
      exp_now = (exp_q.size() == 0) ?
                pk(m_ir, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0) : exp_q[0];
      act_now = {ir_q, r_in, r_out, din_out, g_out, a_in, g_in, alu_op, done, illegal, state_dbg};
      chk("outputs", 64'(act_now), 64'(exp_now));
      drivers = int'(r_out != 8'h00) + int'(din_out) + int'(g_out);
      chk("one_bus_driver", 64'(drivers <= 1), 64'd1);
      chk("r_in_onehot0", 64'($onehot0(r_in)), 64'd1);
      chk("done_not_t0", 64'(done && (state_dbg == 2'd0)), 64'd0);
      // Advance the model with the inputs the DUT samples at the next edge.
      if (!rst) begin
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
        end else if (run) begin
          model_load(din);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_instr(input logic [8:0] instr, input logic [8:0] imm);
    @(posedge clk); #1;
    run = 1'b1;
    din = instr;
    @(posedge clk); #1;
    run = 1'b0;
    din = imm;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      run = 1'b0;
      din = 9'($urandom_range(0, 511));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] b2b_din[8];
    vectors     = 0;
    miscompares = 0;
`ifdef PROC_CTRL_LOGIC_EN
    logic_en = 1'b1;
`else
    logic_en = 1'b0;
`endif
    m_ir = '0;
    rst  = 1'b1;
    run  = 1'b1;
    din  = 9'h1ff;

    // Reset with RUN held high: must stay in T0 with IR=0.
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 64'(state_dbg), 64'd0);
    chk("reset_ir", 64'(ir_q), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run = 1'b0;
    idle_cycles(2);

    // mvi R3,#5
    start_instr(9'b001_011_000, 9'd5);
    @(negedge clk);
    chk("mvi_din_out", 64'(din_out), 64'd1);
    chk("mvi_r_in", 64'(r_in), 64'h08);
    chk("mvi_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("mvi_back_t0", 64'(state_dbg), 64'd0);

    // add R1,R2
    start_instr(9'b010_001_010, 9'd0);
    @(negedge clk);
    chk("add_t1_r_out", 64'(r_out), 64'h02);
    chk("add_t1_a_in", 64'(a_in), 64'd1);
    @(negedge clk);
    chk("add_t2_r_out", 64'(r_out), 64'h04);
    chk("add_t2_g_in", 64'(g_in), 64'd1);
    chk("add_t2_alu", 64'(alu_op), 64'd0);
    @(negedge clk);
    chk("add_t3_g_out", 64'(g_out), 64'd1);
    chk("add_t3_r_in", 64'(r_in), 64'h02);
    chk("add_t3_done", 64'(done), 64'd1);

    // mv R7,R7 then sub R0,R0
    start_instr(9'b000_111_111, 9'd0);
    @(negedge clk);
    chk("mv77_r_out", 64'(r_out), 64'h80);
    chk("mv77_r_in", 64'(r_in), 64'h80);
    chk("mv77_done", 64'(done), 64'd1);
    start_instr(9'b011_000_000, 9'd0);
    @(negedge clk);
    @(negedge clk);
    chk("sub_t2_alu", 64'(alu_op), 64'd1);
    idle_cycles(2);

    // Opcode 110 is always illegal.
    start_instr(9'b110_010_001, 9'd0);
    @(negedge clk);
    chk("op110_done", 64'(done), 64'd1);
    chk("op110_illegal", 64'(illegal), 64'd1);
    chk("op110_r_in", 64'(r_in), 64'h00);
    idle_cycles(1);

    // Opcode 100: and when the logic ops are built in, illegal otherwise.
    start_instr(9'b100_010_001, 9'd0);
    @(negedge clk);
`ifdef PROC_CTRL_LOGIC_EN
    chk("op100_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    chk("op100_t2_alu", 64'(alu_op), 64'd2);
    idle_cycles(2);
`else
    chk("op100_illegal", 64'(illegal), 64'd1);
    chk("op100_done", 64'(done), 64'd1);
    idle_cycles(1);
`endif

    // Reset in T2 of add: outputs clear in the same cycle, RUN ignored.
    start_instr(9'b010_101_110, 9'd0);
    @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    run = 1'b1;
    din = 9'b000_001_010;
    #1;
    chk("rst_mid_state", 64'(state_dbg), 64'd0);
    chk("rst_mid_ir", 64'(ir_q), 64'd0);
    chk("rst_mid_ctrl", 64'({r_in, r_out, din_out, g_out, a_in, g_in, alu_op, done, illegal}), 64'd0);
    @(posedge clk); #1;
    chk("rst_run_ignored", 64'(state_dbg), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    run = 1'b0;
    idle_cycles(2);

    // Back-to-back with RUN held: mv, add, mvi. Cycle 1 is the first T0
    // with RUN high; DONE is expected in cycles 2, 6 and 8.
    b2b_din[0] = 9'b000_011_100;
    b2b_din[1] = 9'h0aa;
    b2b_din[2] = 9'b010_110_001;
    b2b_din[3] = 9'h155;
    b2b_din[4] = 9'h0f0;
    b2b_din[5] = 9'h10f;
    b2b_din[6] = 9'b001_101_000;
    b2b_din[7] = 9'd77;
    done_cycles.delete();
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      run = 1'b1;
      din = b2b_din[c-1];
      @(negedge clk);
      if (done) done_cycles.push_back(c);
    end
    @(posedge clk); #1;
    run = 1'b0;
    chk("b2b_done_count", 64'(done_cycles.size()), 64'd3);
    if (done_cycles.size() == 3) begin
      chk("b2b_done_1", 64'(done_cycles[0]), 64'd2);
      chk("b2b_done_2", 64'(done_cycles[1]), 64'd6);
      chk("b2b_done_3", 64'(done_cycles[2]), 64'd8);
    end
    idle_cycles(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) < 2);
      run = ($urandom_range(0, 2) != 0);
      din = 9'($urandom_range(0, 511));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run = 1'b0;
    idle_cycles(5);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
